// File: rtl/iwm_pkg.sv
// Shared definitions for the IWM write path: serializer states, bit-cell timing
// and the handshake register bit positions driven by the serializer.
package iwm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_SHIFT    = 2'd2,
    ST_UNDERRUN = 2'd3
  } iwm_wr_state_t;

  localparam int IWM_BIT_CELL_TICKS = 16;
  localparam int IWM_BITS_PER_BYTE  = 8;

  // Positions inside the IWM handshake register.
  localparam int IWM_HS_BUSY_BIT     = 7;
  localparam int IWM_HS_UNDERRUN_BIT = 6;

endpackage

// File: rtl/iwm_write_serializer_if.sv
// CPU-side and floppy-side signals of the IWM write serializer.
interface iwm_write_serializer_if;
  logic       wr_mode;
  logic       data_we;
  logic [7:0] data_in;
  logic       buffer_empty;
  logic       underrun_n;
  logic       wr_data;
  logic       byte_done;
  logic       busy;

  modport master (
    output wr_mode, data_we, data_in,
    input  buffer_empty, underrun_n, wr_data, byte_done, busy
  );

  modport slave (
    input  wr_mode, data_we, data_in,
    output buffer_empty, underrun_n, wr_data, byte_done, busy
  );
endinterface

// File: rtl/iwm_bitcell_timer.sv
// cen-gated bit-cell counter. The start tick itself counts as position 0 of the
// first cell, so the counter resumes at 1 right after a start.
module iwm_bitcell_timer #(
  parameter int BIT_CELL_TICKS = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic cen,
  input  logic start,
  input  logic clear,
  output logic cell_start,
  output logic cell_end
);

  localparam int W = $clog2(BIT_CELL_TICKS);

  logic [W-1:0] cnt_q, cnt_d;
  logic         run_q, run_d;

  assign cell_start = run_q && (cnt_q == '0);
  assign cell_end   = run_q && (cnt_q == W'(BIT_CELL_TICKS - 1));

  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    if (cen) begin
      if (clear) begin
        cnt_d = '0;
        run_d = 1'b0;
      end else if (start) begin
        cnt_d = W'(1);
        run_d = 1'b1;
      end else if (run_q) begin
        cnt_d = cell_end ? '0 : cnt_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/iwm_write_serializer.sv
// IWM write data path: CPU byte holding register, MSB-first serializer and
// transition-encoded write line, plus the _iwmBusy/_writeUnderrun handshake.
module iwm_write_serializer
  import iwm_pkg::*;
#(
  parameter int BIT_CELL_TICKS = IWM_BIT_CELL_TICKS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cen,
  iwm_write_serializer_if.slave  bus
);

  localparam int BITS_PER_BYTE = IWM_BITS_PER_BYTE;
  localparam int BIT_W         = $clog2(BITS_PER_BYTE);

  iwm_wr_state_t    state_q, state_d;
  logic [7:0]       hold_q, hold_d;
  logic             full_q, full_d;
  logic [7:0]       shift_q, shift_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             wr_data_q, wr_data_d;
  logic             byte_done_q, byte_done_d;
  logic             load;
  logic             timer_start, timer_clear;
  logic             cell_start, cell_end;

  iwm_bitcell_timer #(
    .BIT_CELL_TICKS (BIT_CELL_TICKS)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .cen        (cen),
    .start      (timer_start),
    .clear      (timer_clear),
    .cell_start (cell_start),
    .cell_end   (cell_end)
  );

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    full_d      = full_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    wr_data_d   = wr_data_q;
    byte_done_d = byte_done_q;
    load        = 1'b0;
    timer_start = 1'b0;
    timer_clear = 1'b0;

    if (cen) begin
      byte_done_d = 1'b0;
      if (!bus.wr_mode) begin
        state_d     = ST_IDLE;
        hold_d      = '0;
        full_d      = 1'b0;
        bit_cnt_d   = '0;
        timer_clear = 1'b1;
      end else begin
        if (state_q != ST_IDLE && bus.data_we) begin
          hold_d = bus.data_in;
          full_d = 1'b1;
        end

        case (state_q)
          ST_IDLE:  state_d = ST_ARMED;
          ST_ARMED: load = full_q;
          ST_SHIFT: begin
            if (cell_end) begin
              shift_d   = {shift_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end else if (cell_start) begin
              // Counter wrapped back to 0 after the eighth shift: byte boundary.
              if (bit_cnt_q == '0) begin
                byte_done_d = 1'b1;
                if (full_q) begin
                  load = 1'b1;
                end else begin
                  state_d     = ST_UNDERRUN;
                  timer_clear = 1'b1;
                end
              end else if (shift_q[7]) begin
                wr_data_d = ~wr_data_q;
              end
            end
          end
          default: ;
        endcase

        // The load tick is cell 0 of the new byte, so its MSB is emitted here.
        if (load) begin
          shift_d     = hold_q;
          full_d      = bus.data_we;
          state_d     = ST_SHIFT;
          bit_cnt_d   = '0;
          timer_start = 1'b1;
          if (hold_q[7]) wr_data_d = ~wr_data_q;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      full_q      <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      wr_data_q   <= 1'b0;
      byte_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      full_q      <= full_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      wr_data_q   <= wr_data_d;
      byte_done_q <= byte_done_d;
    end
  end

  assign bus.buffer_empty = ~full_q;
  assign bus.underrun_n   = (state_q != ST_UNDERRUN);
  assign bus.busy         = (state_q == ST_SHIFT);
  assign bus.wr_data      = wr_data_q;
  assign bus.byte_done    = byte_done_q;

endmodule

// File: tb/tb_iwm_write_serializer.sv
// Directed bench for the IWM write serializer: per-tick traces of the outputs
// are compared against hand-derived bit-cell positions.
module tb_iwm_write_serializer;

  logic clk = 1'b0;
  logic reset;
  logic cen;
  int   checks = 0;
  int   errors = 0;

  logic [511:0] tog, dn, be, un;
  logic [511:0] exp_tog, exp_dn, exp_be, exp_un;

  iwm_write_serializer_if bus ();

  iwm_write_serializer dut (
    .clk   (clk),
    .reset (reset),
    .cen   (cen),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs n cen ticks, optionally writing bytes at two indices, and records per tick
  // whether wr_data changed plus byte_done, buffer_empty and underrun_n levels.
  task automatic run_ticks(input int n, input int wa, input logic [7:0] da,
                           input int wb, input logic [7:0] db,
                           output logic [511:0] t, output logic [511:0] d,
                           output logic [511:0] b, output logic [511:0] u);
    logic prev;
    prev = bus.wr_data;
    t = '0; d = '0; b = '0; u = '0;
    for (int i = 0; i < n; i++) begin
      bus.data_we = (i == wa) || (i == wb);
      bus.data_in = (i == wa) ? da : db;
      tick();
      bus.data_we = 1'b0;
      t[i] = (bus.wr_data !== prev);
      prev = bus.wr_data;
      d[i] = bus.byte_done;
      b[i] = bus.buffer_empty;
      u[i] = bus.underrun_n;
    end
  endtask

  task automatic write_byte(input logic [7:0] v);
    bus.data_we = 1'b1;
    bus.data_in = v;
    tick();
    bus.data_we = 1'b0;
  endtask

  task automatic rearm();
    bus.wr_mode = 1'b0;
    tick();
    bus.wr_mode = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; cen = 1'b0;
    bus.wr_mode = 1'b0; bus.data_we = 1'b0; bus.data_in = 8'h00;
    repeat (3) tick();
    checks++; if (bus.buffer_empty !== 1'b1) begin errors++; $display("FAIL reset_buffer_empty: got %b expected 1", bus.buffer_empty); end
    checks++; if (bus.underrun_n !== 1'b1) begin errors++; $display("FAIL reset_underrun_n: got %b expected 1", bus.underrun_n); end
    checks++; if (bus.wr_data !== 1'b0) begin errors++; $display("FAIL reset_wr_data: got %b expected 0", bus.wr_data); end
    checks++; if (bus.byte_done !== 1'b0) begin errors++; $display("FAIL reset_byte_done: got %b expected 0", bus.byte_done); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    reset = 1'b0;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_single_ff();
    cen = 1'b1;
    bus.wr_mode = 1'b1;
    tick();
    write_byte(8'hFF);
    checks++; if (bus.buffer_empty !== 1'b0) begin errors++; $display("FAIL ff_be_after_we: got %b expected 0", bus.buffer_empty); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ff_busy_before_load: got %b expected 0", bus.busy); end
    run_ticks(140, -1, 8'h00, -1, 8'h00, tog, dn, be, un);
    exp_tog = '0;
    exp_tog[0] = 1'b1; exp_tog[16] = 1'b1; exp_tog[32] = 1'b1; exp_tog[48] = 1'b1;
    exp_tog[64] = 1'b1; exp_tog[80] = 1'b1; exp_tog[96] = 1'b1; exp_tog[112] = 1'b1;
    exp_dn = '0; exp_dn[128] = 1'b1;
    exp_un = '0; for (int i = 0; i < 128; i++) exp_un[i] = 1'b1;
    exp_be = '0; for (int i = 0; i < 140; i++) exp_be[i] = 1'b1;
    checks++; if (tog !== exp_tog) begin errors++; $display("FAIL ff_toggles: got %h expected %h", tog[139:0], exp_tog[139:0]); end
    checks++; if (dn !== exp_dn) begin errors++; $display("FAIL ff_byte_done: got %h expected %h", dn[139:0], exp_dn[139:0]); end
    checks++; if (un !== exp_un) begin errors++; $display("FAIL ff_underrun_n: got %h expected %h", un[139:0], exp_un[139:0]); end
    checks++; if (be !== exp_be) begin errors++; $display("FAIL ff_buffer_empty: got %h expected %h", be[139:0], exp_be[139:0]); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ff_busy_in_underrun: got %b expected 0", bus.busy); end
    write_byte(8'h5A);
    checks++; if (bus.buffer_empty !== 1'b0) begin errors++; $display("FAIL underrun_accepts_we: got %b expected 0", bus.buffer_empty); end
    run_ticks(20, -1, 8'h00, -1, 8'h00, tog, dn, be, un);
    checks++; if (tog !== '0 || bus.busy !== 1'b0 || bus.underrun_n !== 1'b0) begin errors++; $display("FAIL underrun_holds: got tog=%h busy=%b un=%b expected tog=0 busy=0 un=0", tog[19:0], bus.busy, bus.underrun_n); end
    bus.wr_mode = 1'b0;
    tick();
    checks++; if (bus.underrun_n !== 1'b1 || bus.buffer_empty !== 1'b1) begin errors++; $display("FAIL underrun_exit: got un=%b be=%b expected un=1 be=1", bus.underrun_n, bus.buffer_empty); end
    $display("test_single_ff done");
  endtask

  task automatic test_pattern_96();
    bus.wr_mode = 1'b1;
    tick();
    write_byte(8'h96);
    run_ticks(140, -1, 8'h00, -1, 8'h00, tog, dn, be, un);
    exp_tog = '0;
    exp_tog[0] = 1'b1; exp_tog[48] = 1'b1; exp_tog[80] = 1'b1; exp_tog[96] = 1'b1;
    exp_dn = '0; exp_dn[128] = 1'b1;
    checks++; if (tog !== exp_tog) begin errors++; $display("FAIL p96_toggles: got %h expected %h", tog[139:0], exp_tog[139:0]); end
    checks++; if (dn !== exp_dn) begin errors++; $display("FAIL p96_byte_done: got %h expected %h", dn[139:0], exp_dn[139:0]); end
    checks++; if (bus.wr_data !== 1'b0) begin errors++; $display("FAIL p96_final_level: got %b expected 0", bus.wr_data); end
    $display("test_pattern_96 done");
  endtask

  task automatic test_no_gap();
    rearm();
    write_byte(8'hA5);
    checks++; if (bus.buffer_empty !== 1'b0) begin errors++; $display("FAIL nogap_be_first: got %b expected 0", bus.buffer_empty); end
    run_ticks(270, 127, 8'h3C, -1, 8'h00, tog, dn, be, un);
    exp_tog = '0;
    exp_tog[0] = 1'b1; exp_tog[32] = 1'b1; exp_tog[80] = 1'b1; exp_tog[112] = 1'b1;
    exp_tog[160] = 1'b1; exp_tog[176] = 1'b1; exp_tog[192] = 1'b1; exp_tog[208] = 1'b1;
    exp_dn = '0; exp_dn[128] = 1'b1; exp_dn[256] = 1'b1;
    exp_be = '0; exp_un = '0;
    for (int i = 0; i < 270; i++) begin
      exp_be[i] = (i != 127);
      exp_un[i] = (i < 256);
    end
    checks++; if (tog !== exp_tog) begin errors++; $display("FAIL nogap_toggles: got %h expected %h", tog[269:0], exp_tog[269:0]); end
    checks++; if (dn !== exp_dn) begin errors++; $display("FAIL nogap_byte_done: got %h expected %h", dn[269:0], exp_dn[269:0]); end
    checks++; if (be !== exp_be) begin errors++; $display("FAIL nogap_buffer_empty: got %h expected %h", be[269:0], exp_be[269:0]); end
    checks++; if (un !== exp_un) begin errors++; $display("FAIL nogap_underrun_n: got %h expected %h", un[269:0], exp_un[269:0]); end
    $display("test_no_gap done");
  endtask

  task automatic test_back_to_back();
    // Overwrite: 0x11 is replaced by 0x22 before the reload.
    rearm();
    write_byte(8'h01);
    run_ticks(270, 10, 8'h11, 20, 8'h22, tog, dn, be, un);
    exp_tog = '0; exp_tog[112] = 1'b1; exp_tog[160] = 1'b1; exp_tog[224] = 1'b1;
    exp_dn = '0; exp_dn[128] = 1'b1; exp_dn[256] = 1'b1;
    exp_be = '0; exp_un = '0;
    for (int i = 0; i < 270; i++) begin
      exp_be[i] = !(i >= 10 && i < 128);
      exp_un[i] = (i < 256);
    end
    checks++; if (tog !== exp_tog) begin errors++; $display("FAIL overwrite_toggles: got %h expected %h", tog[269:0], exp_tog[269:0]); end
    checks++; if (dn !== exp_dn) begin errors++; $display("FAIL overwrite_byte_done: got %h expected %h", dn[269:0], exp_dn[269:0]); end
    checks++; if (be !== exp_be) begin errors++; $display("FAIL overwrite_buffer_empty: got %h expected %h", be[269:0], exp_be[269:0]); end
    checks++; if (un !== exp_un) begin errors++; $display("FAIL overwrite_underrun_n: got %h expected %h", un[269:0], exp_un[269:0]); end
    // Write landing on the reload tick: 0xC0 shifts, 0x40 stays held and follows.
    rearm();
    write_byte(8'h80);
    run_ticks(400, 50, 8'hC0, 128, 8'h40, tog, dn, be, un);
    exp_tog = '0; exp_tog[0] = 1'b1; exp_tog[128] = 1'b1; exp_tog[144] = 1'b1; exp_tog[272] = 1'b1;
    exp_dn = '0; exp_dn[128] = 1'b1; exp_dn[256] = 1'b1; exp_dn[384] = 1'b1;
    exp_be = '0; exp_un = '0;
    for (int i = 0; i < 400; i++) begin
      exp_be[i] = !(i >= 50 && i < 256);
      exp_un[i] = (i < 384);
    end
    checks++; if (tog !== exp_tog) begin errors++; $display("FAIL simul_toggles: got %h expected %h", tog[399:0], exp_tog[399:0]); end
    checks++; if (dn !== exp_dn) begin errors++; $display("FAIL simul_byte_done: got %h expected %h", dn[399:0], exp_dn[399:0]); end
    checks++; if (be !== exp_be) begin errors++; $display("FAIL simul_buffer_empty: got %h expected %h", be[399:0], exp_be[399:0]); end
    checks++; if (un !== exp_un) begin errors++; $display("FAIL simul_underrun_n: got %h expected %h", un[399:0], exp_un[399:0]); end
    $display("test_back_to_back done");
  endtask

  task automatic test_abort();
    // wr_data ends the previous test at 1; three 0xFF cells bring it to 0.
    rearm();
    write_byte(8'hFF);
    run_ticks(48, 20, 8'h77, -1, 8'h00, tog, dn, be, un);
    exp_tog = '0; exp_tog[0] = 1'b1; exp_tog[16] = 1'b1; exp_tog[32] = 1'b1;
    checks++; if (tog !== exp_tog || be[47] !== 1'b0) begin errors++; $display("FAIL abort_prefix: got tog=%h be=%b expected tog=%h be=0", tog[47:0], be[47], exp_tog[47:0]); end
    bus.wr_mode = 1'b0;
    tick();
    checks++; if (bus.busy !== 1'b0 || bus.buffer_empty !== 1'b1 || bus.underrun_n !== 1'b1) begin errors++; $display("FAIL abort_idle: got busy=%b be=%b un=%b expected 0 1 1", bus.busy, bus.buffer_empty, bus.underrun_n); end
    checks++; if (bus.wr_data !== 1'b0) begin errors++; $display("FAIL abort_level: got %b expected 0", bus.wr_data); end
    run_ticks(40, 5, 8'hFF, -1, 8'h00, tog, dn, be, un);
    exp_be = '0; for (int i = 0; i < 40; i++) exp_be[i] = 1'b1;
    checks++; if (tog !== '0 || be !== exp_be) begin errors++; $display("FAIL abort_quiet: got tog=%h be=%h expected tog=0 be=%h", tog[39:0], be[39:0], exp_be[39:0]); end
    bus.wr_mode = 1'b1;
    tick();
    checks++; if (bus.busy !== 1'b0 || bus.underrun_n !== 1'b1) begin errors++; $display("FAIL rearm_armed: got busy=%b un=%b expected 0 1", bus.busy, bus.underrun_n); end
    write_byte(8'h00);
    tick();
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rearm_load: got busy=%b expected 1", bus.busy); end
    $display("test_abort done");
  endtask

  task automatic test_async_reset();
    rearm();
    write_byte(8'hFF);
    run_ticks(40, -1, 8'h00, -1, 8'h00, tog, dn, be, un);
    checks++; if (bus.wr_data !== 1'b1 || bus.busy !== 1'b1) begin errors++; $display("FAIL prereset_state: got wr=%b busy=%b expected 1 1", bus.wr_data, bus.busy); end
    cen = 1'b0;
    bus.data_we = 1'b1; bus.data_in = 8'h12;
    repeat (10) tick();
    bus.data_we = 1'b0;
    checks++; if (bus.wr_data !== 1'b1 || bus.busy !== 1'b1 || bus.buffer_empty !== 1'b1 || bus.byte_done !== 1'b0) begin errors++; $display("FAIL cen_hold: got wr=%b busy=%b be=%b bd=%b expected 1 1 1 0", bus.wr_data, bus.busy, bus.buffer_empty, bus.byte_done); end
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.wr_data !== 1'b0 || bus.busy !== 1'b0 || bus.buffer_empty !== 1'b1 || bus.underrun_n !== 1'b1 || bus.byte_done !== 1'b0) begin errors++; $display("FAIL async_reset: got wr=%b busy=%b be=%b un=%b bd=%b expected 0 0 1 1 0", bus.wr_data, bus.busy, bus.buffer_empty, bus.underrun_n, bus.byte_done); end
    repeat (2) tick();
    reset = 1'b0;
    cen = 1'b1;
    tick();
    write_byte(8'hFF);
    run_ticks(140, -1, 8'h00, -1, 8'h00, tog, dn, be, un);
    exp_tog = '0;
    exp_tog[0] = 1'b1; exp_tog[16] = 1'b1; exp_tog[32] = 1'b1; exp_tog[48] = 1'b1;
    exp_tog[64] = 1'b1; exp_tog[80] = 1'b1; exp_tog[96] = 1'b1; exp_tog[112] = 1'b1;
    exp_dn = '0; exp_dn[128] = 1'b1;
    exp_un = '0; for (int i = 0; i < 128; i++) exp_un[i] = 1'b1;
    checks++; if (tog !== exp_tog) begin errors++; $display("FAIL postreset_toggles: got %h expected %h", tog[139:0], exp_tog[139:0]); end
    checks++; if (dn !== exp_dn) begin errors++; $display("FAIL postreset_byte_done: got %h expected %h", dn[139:0], exp_dn[139:0]); end
    checks++; if (un !== exp_un) begin errors++; $display("FAIL postreset_underrun_n: got %h expected %h", un[139:0], exp_un[139:0]); end
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_single_ff();
    test_pattern_96();
    test_no_gap();
    test_back_to_back();
    test_abort();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
